// File: rtl/maxpool_mul_pkg.sv
// Shared definitions for the MaxPooling pipelined multiplier / multiply-accumulate core.
package maxpool_mul_pkg;

    localparam int MUL_MIN_STAGE = 2;
    localparam int MUL_MAX_STAGE = 8;

    // Width both operands are extended to before the multiply.
    function automatic int mul_ext_width(input int w0, input int w1);
        return w0 + w1 + 1;
    endfunction

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } mul_sband_t;

endpackage

// File: rtl/maxpool_mul_acc_pipe_if.sv
// Beat-in / result-out bus of the multiplier core; the core takes the slave side.
interface maxpool_mul_acc_pipe_if #(
    parameter int DIN0_WIDTH = 62,
    parameter int DIN1_WIDTH = 32,
    parameter int DOUT_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_first;
    logic                  in_last;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic [DOUT_WIDTH-1:0] dout;

    modport master (
        output in_valid, in_first, in_last, din0, din1,
        input  out_valid, dout
    );

    modport slave (
        input  in_valid, in_first, in_last, din0, din1,
        output out_valid, dout
    );
endinterface

// File: rtl/maxpool_mul_sband_dly.sv
// Clock-enabled delay line for the valid/first/last sideband, cleared by synchronous reset.
module maxpool_mul_sband_dly
    import maxpool_mul_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  mul_sband_t d,
    output mul_sband_t q
);

    mul_sband_t stage_q [DEPTH];

    // NOTE: only the sideband is reset; a cleared valid bit is enough to discard in-flight data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (ce) begin
            stage_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/maxpool_mul_acc_pipe.sv
// Pipelined signed/unsigned multiplier with optional framed accumulate, stalled by ce.
module maxpool_mul_acc_pipe
    import maxpool_mul_pkg::*;
#(
    parameter int DIN0_WIDTH  = 62,
    parameter int DIN1_WIDTH  = 32,
    parameter int DOUT_WIDTH  = 64,
    parameter int NUM_STAGE   = 5,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 1,
    parameter int ACC_EN      = 0
) (
    input logic clk,
    input logic reset,
    input logic ce,
    maxpool_mul_acc_pipe_if.slave bus
);

    localparam int EXT_W = mul_ext_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int BUF_N = NUM_STAGE - 2;

    if (NUM_STAGE < MUL_MIN_STAGE || NUM_STAGE > MUL_MAX_STAGE) begin : g_bad_stage
        $error("maxpool_mul_acc_pipe: NUM_STAGE must be in 2..8");
    end
    if (DOUT_WIDTH < 2) begin : g_bad_dout
        $error("maxpool_mul_acc_pipe: DOUT_WIDTH must be at least 2");
    end

    logic [DIN0_WIDTH-1:0] a_q;
    logic [DIN1_WIDTH-1:0] b_q;
    logic [EXT_W-1:0]      a_ext, b_ext, prod_full;
    logic [DOUT_WIDTH-1:0] prod_fit, prod_pre, prod_out;
    mul_sband_t            sb_in, sb_mid, sb_out;

    assign sb_in = '{valid: bus.in_valid, first: bus.in_first, last: bus.in_last};

    // NOTE: datapath registers carry no reset; validity is tracked by the sideband alone.
    always_ff @(posedge clk) begin
        if (ce) begin
            a_q <= bus.din0;
            b_q <= bus.din1;
        end
    end

    assign a_ext     = {{(EXT_W-DIN0_WIDTH){(DIN0_SIGNED != 0) & a_q[DIN0_WIDTH-1]}}, a_q};
    assign b_ext     = {{(EXT_W-DIN1_WIDTH){(DIN1_SIGNED != 0) & b_q[DIN1_WIDTH-1]}}, b_q};
    assign prod_full = a_ext * b_ext;

    if (DOUT_WIDTH <= EXT_W) begin : g_trunc
        assign prod_fit = prod_full[DOUT_WIDTH-1:0];
    end else begin : g_sext
        assign prod_fit = {{(DOUT_WIDTH-EXT_W){prod_full[EXT_W-1]}}, prod_full};
    end

    if (BUF_N > 0) begin : g_buf
        logic [DOUT_WIDTH-1:0] buf_q [BUF_N];
        always_ff @(posedge clk) begin
            if (ce) begin
                buf_q[0] <= prod_fit;
                for (int i = 1; i < BUF_N; i++) buf_q[i] <= buf_q[i-1];
            end
        end
        assign prod_pre = buf_q[BUF_N-1];
    end else begin : g_nobuf
        assign prod_pre = prod_fit;
    end

    // Stages 1..NUM_STAGE-1 of sideband; the output stage is registered below.
    maxpool_mul_sband_dly #(.DEPTH(NUM_STAGE - 1)) u_sband_dly (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .d     (sb_in),
        .q     (sb_mid)
    );

    // Output register only loads on valid beats so dout holds its last result.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_out   <= '0;
            prod_out <= '0;
        end else if (ce) begin
            sb_out <= sb_mid;
            if (sb_mid.valid) prod_out <= prod_pre;
        end
    end

    if (ACC_EN == 0) begin : g_mul
        assign bus.out_valid = sb_out.valid;
        assign bus.dout      = prod_out;
    end else begin : g_acc
        logic [DOUT_WIDTH-1:0] acc_q, sum_q, acc_next;
        logic                  vld_q;

        // A first beat restarts the sum, abandoning any open group.
        assign acc_next = sb_out.first ? prod_out : acc_q + prod_out;

        always_ff @(posedge clk) begin
            if (reset) begin
                acc_q <= '0;
                sum_q <= '0;
                vld_q <= 1'b0;
            end else if (ce) begin
                vld_q <= sb_out.valid & sb_out.last;
                if (sb_out.valid) begin
                    acc_q <= acc_next;
                    if (sb_out.last) sum_q <= acc_next;
                end
            end
        end

        assign bus.out_valid = vld_q;
        assign bus.dout      = sum_q;
    end

endmodule

// File: tb/tb_maxpool_mul_acc_pipe.sv
// Scoreboard bench: dut_a defaults, dut_b signed din0, dut_c signed din0 with accumulate.
module tb_maxpool_mul_acc_pipe;

    localparam int NUM_STAGE = 5;

    typedef struct {
        int          id;
        logic [63:0] value;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    int   edge_cnt  = 0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    bit   edge_en;
    exp_t sb_q [$];

    always #5 clk = ~clk;

    maxpool_mul_acc_pipe_if a_if ();
    maxpool_mul_acc_pipe_if b_if ();
    maxpool_mul_acc_pipe_if c_if ();

    maxpool_mul_acc_pipe #(.NUM_STAGE(NUM_STAGE)) dut_a (
        .clk(clk), .reset(reset), .ce(ce), .bus(a_if.slave)
    );
    maxpool_mul_acc_pipe #(.NUM_STAGE(NUM_STAGE), .DIN0_SIGNED(1)) dut_b (
        .clk(clk), .reset(reset), .ce(ce), .bus(b_if.slave)
    );
    maxpool_mul_acc_pipe #(.NUM_STAGE(NUM_STAGE), .DIN0_SIGNED(1), .ACC_EN(1)) dut_c (
        .clk(clk), .reset(reset), .ce(ce), .bus(c_if.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic clear_ins();
        a_if.in_valid = 0; a_if.in_first = 0; a_if.in_last = 0; a_if.din0 = '0; a_if.din1 = '0;
        b_if.in_valid = 0; b_if.in_first = 0; b_if.in_last = 0; b_if.din0 = '0; b_if.din1 = '0;
        c_if.in_valid = 0; c_if.in_first = 0; c_if.in_last = 0; c_if.din0 = '0; c_if.din1 = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ce = 1'b1;
            clear_ins();
        end
    endtask

    // Present one beat at the next negedge; captured on the following (enabled) edge.
    task automatic beat(input int id, input logic v, input logic [61:0] a, input logic [31:0] b,
                        input logic f, input logic l, input bit push, input logic [63:0] exp);
        @(negedge clk);
        ce = 1'b1;
        clear_ins();
        case (id)
            0: begin a_if.in_valid = v; a_if.in_first = f; a_if.in_last = l; a_if.din0 = a; a_if.din1 = b; end
            1: begin b_if.in_valid = v; b_if.in_first = f; b_if.in_last = l; b_if.din0 = a; b_if.din1 = b; end
            default: begin c_if.in_valid = v; c_if.in_first = f; c_if.in_last = l; c_if.din0 = a; c_if.din1 = b; end
        endcase
        if (push) sb_q.push_back('{id, exp, edge_cnt + 1 + ((id == 2) ? NUM_STAGE : NUM_STAGE - 1)});
    endtask

    // ce low for n cycles while a junk beat sits on dut_a's inputs; it must not be captured.
    task automatic stall(input int n);
        repeat (n) begin
            @(negedge clk);
            ce = 1'b0;
            clear_ins();
            a_if.in_valid = 1'b1; a_if.din0 = 62'd7; a_if.din1 = 32'd7;
        end
    endtask

    task automatic mon(input int id, input logic v, input logic [63:0] d);
        exp_t e;
        if (v) begin
            if (sb_q.size() == 0 || sb_q[0].id != id) begin
                total_cnt++;
                $display("FAIL unexpected_out dut%0d: got %h at edge %0d, no result expected", id, d, edge_cnt);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("dut%0d_value", id), d, e.value);
                check($sformatf("dut%0d_latency_edge", id), 64'(edge_cnt), 64'(e.due));
            end
        end
    endtask

    // Monitor: only enabled edges can present a new result.
    always @(posedge clk) begin
        edge_en = ce && !reset;
        #1;
        if (edge_en) begin
            edge_cnt++;
            mon(0, a_if.out_valid, a_if.dout);
            mon(1, b_if.out_valid, b_if.dout);
            mon(2, c_if.out_valid, c_if.dout);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ce = 1'b1;
        reset = 1'b1;
        clear_ins();
        repeat (3) @(negedge clk);
        check("reset_a_valid", 64'(a_if.out_valid), 64'd0);
        check("reset_a_dout",  a_if.dout, 64'd0);
        check("reset_b_valid", 64'(b_if.out_valid), 64'd0);
        check("reset_b_dout",  b_if.dout, 64'd0);
        check("reset_c_valid", 64'(c_if.out_valid), 64'd0);
        check("reset_c_dout",  c_if.dout, 64'd0);
        reset = 1'b0;

        // 3 x -5 = -15, then dout must hold with out_valid low
        beat(0, 1, 62'd3, 32'hFFFF_FFFB, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF1);
        idle(7);
        check("hold_valid", 64'(a_if.out_valid), 64'd0);
        check("hold_dout",  a_if.dout, 64'hFFFF_FFFF_FFFF_FFF1);

        // unsigned (2^62-1) x -1, then signed -1 x -1 on dut_b
        beat(0, 1, {62{1'b1}}, 32'hFFFF_FFFF, 0, 0, 1, 64'hC000_0000_0000_0001);
        beat(1, 1, {62{1'b1}}, 32'hFFFF_FFFF, 0, 0, 1, 64'd1);
        idle(7);

        // back-to-back beats with a 2-cycle stall while two are in flight
        beat(0, 1, 62'd1, 32'd1, 0, 0, 1, 64'd1);
        beat(0, 1, 62'd2, 32'd2, 0, 0, 1, 64'd4);
        stall(2);
        beat(0, 1, 62'd3, 32'd3, 0, 0, 1, 64'd9);
        idle(8);

        // two beats in flight, reset with ce low: flushed, outputs cleared
        beat(0, 1, 62'd5, 32'd5, 0, 0, 0, 64'd0);
        beat(0, 1, 62'd6, 32'd6, 0, 0, 0, 64'd0);
        @(negedge clk);
        clear_ins();
        ce = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("flush_valid", 64'(a_if.out_valid), 64'd0);
        check("flush_dout",  a_if.dout, 64'd0);
        reset = 1'b0;
        idle(10);

        // accumulate: beat before any first adds onto zero
        beat(2, 1, 62'd3, 32'd4, 0, 1, 1, 64'd12);
        // 6 + 20 - 7 = 19, with an invalid first/last beat in the middle that must be ignored
        beat(2, 1, 62'd2, 32'd3, 1, 0, 0, 64'd0);
        beat(2, 1, 62'd4, 32'd5, 0, 0, 0, 64'd0);
        beat(2, 0, 62'd9, 32'd9, 1, 1, 0, 64'd0);
        beat(2, 1, {62{1'b1}}, 32'd7, 0, 1, 1, 64'd19);
        // single-element group
        beat(2, 1, 62'd6, 32'd6, 1, 1, 1, 64'd36);
        // first re-asserted mid-group: 1 + 4 = 5
        beat(2, 1, 62'd5, 32'd5, 1, 0, 0, 64'd0);
        beat(2, 1, 62'd1, 32'd1, 1, 0, 0, 64'd0);
        beat(2, 1, 62'd2, 32'd2, 0, 1, 1, 64'd5);
        idle(12);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
